// File: rtl/seven_segment_scan_pkg.sv
// Shared display definitions: hex glyph table and an index-width helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seven_segment_scan_pkg;

  // Raw segment pattern for a blanked digit, before any polarity inversion.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Standard hex glyphs in gfedcba order (no decimal point).
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h00;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int log2_ceil(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/seven_segment_scan_seven_segment.sv
// Hex-to-seven-segment decoder: {dot, nibble} -> pgfedcba.
// Latency: combinational.
// Backpressure: none.
module seven_segment
  import seven_segment_scan_pkg::*;
(
  input  logic [4:0] value,
  output logic [7:0] segments
);

  // The dot passes straight through to p; the nibble selects a glyph.
  assign segments = {value[4], glyph(value[3:0])};

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner with frame-aligned display updates.
// Latency: outputs are registered, one cycle behind the scan counters.
// Backpressure: none; load_i is a strobe and is always accepted.
module seven_segment_scan
  import seven_segment_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int GAP        = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [4*NUM_DIGITS-1:0]   value_i,
  input  logic [NUM_DIGITS-1:0]     dots_i,
  input  logic                      load_i,
  input  logic                      lz_blank_i,
  output logic [7:0]                segments_o,
  output logic [NUM_DIGITS-1:0]     digit_sel_o,
  output logic                      frame_o
);

  localparam int IW = log2_ceil(NUM_DIGITS);
  localparam int CW = log2_ceil(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP);
  // XOR masks applied at the output registers; they also define "off".
  localparam logic [7:0]            SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_POL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] hold_val;
  logic [NUM_DIGITS-1:0]   hold_dots;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dots;
  logic                    pending;

  logic                    tick;
  logic                    frame_tick;
  logic                    in_gap;
  logic [3:0]              nib;
  logic                    dot;
  logic                    upper_nonzero;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [7:0]              seg_raw;
  logic [7:0]              seg_vis;
  logic [NUM_DIGITS-1:0]   sel_vis;

  assign tick       = (cnt == CNT_LAST);
  assign frame_tick = tick && (idx == IDX_LAST);
  assign in_gap     = (cnt < GAP_END);

  // Slot counter and digit index; idx wraps at the frame boundary.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Holding register catches every load; display only changes on frame boundaries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_val  <= '0;
      hold_dots <= '0;
      disp_val  <= '0;
      disp_dots <= '0;
      pending   <= 1'b0;
    end else begin
      if (load_i) begin
        hold_val  <= value_i;
        hold_dots <= dots_i;
      end
      if (frame_tick) begin
        // A load landing exactly on the boundary bypasses the holding register.
        if (load_i) begin
          disp_val  <= value_i;
          disp_dots <= dots_i;
        end else if (pending) begin
          disp_val  <= hold_val;
          disp_dots <= hold_dots;
        end
        pending <= 1'b0;
      end else if (load_i) begin
        pending <= 1'b1;
      end
    end
  end

  // Select the current digit and look for any non-zero nibble at or above it.
  always_comb begin
    nib           = 4'h0;
    dot           = 1'b0;
    upper_nonzero = 1'b0;
    sel_onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        nib           = disp_val[4*k +: 4];
        dot           = disp_dots[k];
        sel_onehot[k] = 1'b1;
      end
      if ((IW'(k) >= idx) && (disp_val[4*k +: 4] != 4'h0)) begin
        upper_nonzero = 1'b1;
      end
    end
  end

  seven_segment u_seven_segment (
    .value    ({dot, nib}),
    .segments (seg_raw)
  );

  // Digit 0 is never suppressed, so a zero value still shows a single "0".
  assign blank   = lz_blank_i && (idx != '0) && !upper_nonzero;
  assign seg_vis = in_gap ? SEG_BLANK : (blank ? {seg_raw[7], 7'h00} : seg_raw);
  assign sel_vis = in_gap ? '0 : sel_onehot;

  // Output registers; polarity inversion is applied only here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      segments_o  <= SEG_POL;
      digit_sel_o <= SEL_POL;
      frame_o     <= 1'b0;
    end else begin
      segments_o  <= seg_vis ^ SEG_POL;
      digit_sel_o <= sel_vis ^ SEL_POL;
      frame_o     <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan (NUM_DIGITS=4, DIV=8, GAP=2).
// Runs an active-high and an active-low instance from the same stimulus.
// Outputs are checked every cycle against a time-based model plus literal spot checks.
module tb_seven_segment_scan;

  localparam int ND = 4;
  localparam int DV = 8;
  localparam int GP = 2;
  localparam int FRAME = ND * DV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dots = 4'h0;

  logic [7:0]  seg_h, seg_l;
  logic [3:0]  sel_h, sel_l;
  logic        frame_h, frame_l;

  seven_segment_scan #(.NUM_DIGITS(ND), .DIV(DV), .GAP(GP), .ACTIVE_LOW(0)) dut_h (
    .clk_i(clk), .rst_i(rst), .value_i(value), .dots_i(dots), .load_i(load),
    .lz_blank_i(lz), .segments_o(seg_h), .digit_sel_o(sel_h), .frame_o(frame_h)
  );

  seven_segment_scan #(.NUM_DIGITS(ND), .DIV(DV), .GAP(GP), .ACTIVE_LOW(1)) dut_l (
    .clk_i(clk), .rst_i(rst), .value_i(value), .dots_i(dots), .load_i(load),
    .lz_blank_i(lz), .segments_o(seg_l), .digit_sel_o(sel_l), .frame_o(frame_l)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          t = 0;
  bit          mvalid = 1'b0;
  int          vis_i = -1;
  int          vis_c = -1;
  logic [15:0] m_hold, m_disp;
  logic [3:0]  m_hold_d, m_disp_d;
  bit          m_pend;
  logic [7:0]  e_seg, e_seg_l;
  logic [3:0]  e_sel, e_sel_l;
  logic        e_frame;
  int          mc, mi, md;
  bit          mb;

  // Expected outputs follow from elapsed cycles since reset release.
  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1'b1;
      t = 0;
      m_hold = 16'h0; m_disp = 16'h0; m_hold_d = 4'h0; m_disp_d = 4'h0; m_pend = 1'b0;
      e_seg = 8'h00; e_sel = 4'h0; e_frame = 1'b0;
      vis_i = -1; vis_c = -1;
    end else begin
      mc = t % DV;
      mi = (t / DV) % ND;
      vis_c = mc;
      vis_i = mi;
      e_frame = (t % FRAME) == 0;
      if (mc < GP) begin
        e_seg = 8'h00;
        e_sel = 4'h0;
      end else begin
        e_sel = 4'(1 << mi);
        md = int'((m_disp >> (4 * mi)) & 16'hF);
        mb = lz && (mi > 0) && ((m_disp >> (4 * mi)) == 16'h0);
        e_seg = {m_disp_d[mi], mb ? 7'h00 : gl[md]};
      end
      if (load) begin
        m_hold = value; m_hold_d = dots; m_pend = 1'b1;
      end
      if ((t % FRAME) == FRAME - 1) begin
        if (load) begin
          m_disp = value; m_disp_d = dots;
        end else if (m_pend) begin
          m_disp = m_hold; m_disp_d = m_hold_d;
        end
        m_pend = 1'b0;
      end
      t++;
    end
    e_seg_l = ~e_seg;
    e_sel_l = ~e_sel;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("seg", seg_h, e_seg);
      chk("sel", sel_h, e_sel);
      chk("frame", frame_h, e_frame);
      chk("seg_al", seg_l, e_seg_l);
      chk("sel_al", sel_l, e_sel_l);
      chk("frame_al", frame_l, e_frame);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance to the negedge where the visible outputs belong to slot (i, c).
  task automatic run_to(input int i, input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vis_i == i && vis_c == c) && n < 200);
    if (!(vis_i == i && vis_c == c)) begin
      nchk++;
      nerr++;
      $display("FAIL run_to(%0d,%0d): slot not reached in 200 cycles", i, c);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dots  = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [7:0] s, input logic [3:0] d);
    chk({nm, "_seg"}, seg_h, s);
    chk({nm, "_sel"}, sel_h, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset for three cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    lit("rst", 8'h00, 4'h0);
    chk("rst_frame", frame_h, 1'b0);
    chk("rst_seg_al", seg_l, 8'hFF);
    chk("rst_sel_al", sel_l, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_frame", frame_h, 1'b1);
    chk("first_sel", sel_h, 4'h0);
    @(negedge clk);
    chk("second_frame", frame_h, 1'b0);
    chk("second_sel", sel_h, 4'h0);
    @(negedge clk);
    lit("first_digit", 8'h3F, 4'b0001);

    // Basic scan of 0x1234.
    run_to(0, 4);
    do_load(16'h1234, 4'h0);
    run_to(0, 0);
    chk("scan_frame", frame_h, 1'b1);
    run_to(0, 2); lit("scan_d0", 8'h66, 4'b0001);
    run_to(1, 1); lit("scan_gap", 8'h00, 4'b0000);
    run_to(1, 2); lit("scan_d1", 8'h4F, 4'b0010);
    run_to(2, 7); lit("scan_d2", 8'h5B, 4'b0100);
    run_to(3, 2); lit("scan_d3", 8'h06, 4'b1000);
    run_to(0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_h && n < 100);
    chk("frame_period", n, 32);

    // Boundary load bypasses a stale pending value; mid-frame load waits.
    run_to(2, 0);
    do_load(16'h9999, 4'h0);
    run_to(3, 6);
    do_load(16'h1234, 4'h0);
    run_to(0, 4); lit("align_d0", 8'h66, 4'b0001);
    run_to(1, 3);
    do_load(16'hABCD, 4'h0);
    run_to(2, 4); lit("align_old_d2", 8'h5B, 4'b0100);
    run_to(3, 4); lit("align_old_d3", 8'h06, 4'b1000);
    run_to(0, 4); lit("align_new_d0", 8'h5E, 4'b0001);
    run_to(1, 4); lit("align_new_d1", 8'h39, 4'b0010);
    run_to(2, 4); lit("align_new_d2", 8'h7C, 4'b0100);
    run_to(3, 4); lit("align_new_d3", 8'h77, 4'b1000);

    // Leading-zero suppression.
    lz = 1'b1;
    do_load(16'h0050, 4'h0);
    run_to(0, 4); lit("lz_d0", 8'h3F, 4'b0001);
    run_to(1, 4); lit("lz_d1", 8'h6D, 4'b0010);
    run_to(2, 4); lit("lz_d2", 8'h00, 4'b0100);
    run_to(3, 4); lit("lz_d3", 8'h00, 4'b1000);
    do_load(16'h0000, 4'h0);
    run_to(0, 4); lit("lz0_d0", 8'h3F, 4'b0001);
    run_to(1, 4); lit("lz0_d1", 8'h00, 4'b0010);
    run_to(3, 4); lit("lz0_d3", 8'h00, 4'b1000);

    // Decimal point and active-low polarity.
    do_load(16'h000A, 4'b0001);
    run_to(0, 4);
    lit("dot_d0", 8'hF7, 4'b0001);
    chk("al_d0_seg", seg_l, 8'h08);
    chk("al_d0_sel", sel_l, 4'b1110);
    run_to(1, 1);
    chk("al_gap_seg", seg_l, 8'hFF);
    chk("al_gap_sel", sel_l, 4'b1111);

    // Reset mid-frame with a pending load.
    run_to(2, 2);
    do_load(16'h5555, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    lit("midrst", 8'h00, 4'h0);
    chk("midrst_frame", frame_h, 1'b0);
    chk("midrst_seg_al", seg_l, 8'hFF);
    rst = 1'b0;
    run_to(0, 4); lit("post_d0", 8'h3F, 4'b0001);
    run_to(1, 4); lit("post_d1", 8'h00, 4'b0010);
    run_to(0, 4); lit("post2_d0", 8'h3F, 4'b0001);
    run_to(1, 4); lit("post2_d1", 8'h00, 4'b0010);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV, default 1000, meaning clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter GAP, default 2, meaning the all-digits-off cycles at the start of each slot for anti-ghosting (legal 0..DIV-1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; when 1, segments_o and digit_sel_o are bitwise inverted.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port value_i, input, 4*NUM_DIGITS bits: hex nibbles, where nibble k is digit k and digit 0 is the rightmost.
REQ-008 SHALL have port dots_i, input, NUM_DIGITS bits: the decimal point per digit.
REQ-009 SHALL have port load_i, input, 1 bit: a strobe that captures value_i and dots_i.
REQ-010 SHALL have port lz_blank_i, input, 1 bit: enables leading-zero suppression.
REQ-011 SHALL have port segments_o, output, 8 bits: segment pattern in pgfedcba order, registered.
REQ-012 SHALL have port digit_sel_o, output, NUM_DIGITS bits: one-hot digit enable, registered.
REQ-013 SHALL have port frame_o, output, 1 bit: a one-cycle pulse at the start of each scan frame, registered.

Function
REQ-014 SHALL keep a slot counter cnt (0..DIV-1) that increments every cycle and wraps to 0 after DIV-1; that wrap cycle is the "tick".
REQ-015 SHALL keep a digit index idx (0..NUM_DIGITS-1) that advances on each tick and wraps from NUM_DIGITS-1 to 0 (the frame boundary).
REQ-016 SHALL capture value_i/dots_i into a holding register in the cycle load_i=1; the last load in a frame wins.
REQ-017 SHALL copy the holding register into the display register at each frame-boundary tick if a load occurred since the previous copy; otherwise the display register is unchanged.
REQ-018 SHALL copy value_i/dots_i directly into the display register when load_i=1 in the frame-boundary tick cycle.
REQ-019 SHALL register all outputs so they reflect (cnt, idx, display) of the previous cycle, giving 1-cycle latency.
REQ-020 SHALL drive digit_sel_o all-off when cnt < GAP, and one-hot bit idx otherwise.
REQ-021 SHALL drive segments_o as all-off when cnt < GAP; otherwise it SHALL be the hex glyph of display nibble idx with p = dots bit idx.
REQ-022 SHALL blank digit k (a..g off, p still from dots) when lz_blank_i=1, k>0, and nibbles k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-023 SHALL pulse frame_o for one cycle, in the output cycle corresponding to cnt=0, idx=0.
REQ-024 SHALL use glyphs 0..F as standard hex: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-025 SHALL apply ACTIVE_LOW inversion only at the output registers; the reset values in REQ-026 are post-inversion logical "off".

Reset
REQ-026 SHALL, in any cycle rst_i=1 (including mid-frame), set cnt=0, idx=0, holding=0, display=0, pending-load=0, segments_o=off, digit_sel_o=off, frame_o=0.
REQ-027 SHALL give rst_i priority over load_i in the same cycle.
REQ-028 SHALL start scanning at digit 0 in the first cycle after rst_i deasserts, with frame_o=1 one cycle later.

Structure
REQ-029 SHALL place the glyph constants and a log2 helper for idx width in the shared display package.
REQ-030 SHALL instantiate sub-module seven_segment once (5-bit value {dot,nibble} -> pgfedcba), with blanking and inversion applied outside it.

Verification (NUM_DIGITS=4, DIV=8, GAP=2 unless stated)
REQ-031 SHALL cover this reset scenario: rst_i high 3 cycles, then low -> segments_o=00, digit_sel_o=0000 for 3 output cycles, then digit_sel_o=0001 and frame_o pulse once at the cnt=0 output.
REQ-032 SHALL cover this scan scenario: load 0x1234, dots=0, run one frame -> digit0 shows 66, digit1 shows 4F, digit2 shows 5B, digit3 shows 06; each is selected for 6 cycles preceded by 2 off cycles; frame period is 32 cycles.
REQ-033 SHALL cover this frame-aligned update scenario: load 0x1234 at frame start, load 0xABCD during the idx=1 slot -> the rest of the frame shows 1234, and the next frame shows D,C,B,A (5E,39,7C,77).
REQ-034 SHALL cover this leading-zero scenario: value 0x0050, lz_blank_i=1 -> digits 3 and 2 show 00, digit1 shows 6D, digit0 shows 3F; value 0x0000 -> only digit0 shows 3F.
REQ-035 SHALL cover this dot/polarity scenario: value 0x000A, dots=0001 -> digit0 shows F7; with ACTIVE_LOW=1 -> segments_o=08 and digit_sel_o=1110 during the digit0 slot, and FF/1111 during gaps.
REQ-036 SHALL cover this reset mid-operation scenario: rst_i asserted during the idx=2 slot with a pending load -> outputs go off next cycle, the pending load is discarded, and display=0 after release.
